// File: rtl/airlock_pkg.sv
// Shared constants for the airlock sequencer: state codes, direction type and
// default phase durations in seconds.
package airlock_pkg;

  localparam int CNT_W_DEF     = 10;
  localparam int T_DOOR_DEF    = 10;
  localparam int T_PRESS_DEF   = 300;
  localparam int T_DEPRESS_DEF = 420;
  localparam int T_PURGE_DEF   = 480;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE_LO  = 3'd0;
  localparam state_t ST_IDLE_HI  = 3'd1;
  localparam state_t ST_OPEN_OUT = 3'd2;
  localparam state_t ST_PRESS    = 3'd3;
  localparam state_t ST_OPEN_IN  = 3'd4;
  localparam state_t ST_DEPRESS  = 3'd5;
  localparam state_t ST_PURGE    = 3'd6;

  // DIR_NONE marks an empty-chamber transfer used only to swap pressure.
  typedef enum logic [1:0] {
    DIR_NONE = 2'd0,
    DIR_ENT  = 2'd1,
    DIR_EXT  = 2'd2
  } dir_e;

endpackage

// File: rtl/airlock_sequencer_phase_timer.sv
// Shared countdown for the current airlock phase. remaining counts D..1 and
// parks at 1 until the controller reloads or clears it.
module phase_timer
  import airlock_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic             clear,
  input  logic [CNT_W-1:0] dur,
  output logic [CNT_W-1:0] remaining,
  output logic             expired
);

  logic [CNT_W-1:0] rem_q, rem_d;

  always_comb begin
    rem_d = rem_q;
    if (load) begin
      // A zero duration still occupies one cycle.
      rem_d = (dur == '0) ? CNT_W'(1) : dur;
    end else if (clear) begin
      rem_d = '0;
    end else if (rem_q > CNT_W'(1)) begin
      rem_d = rem_q - CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) rem_q <= '0;
    else     rem_q <= rem_d;
  end

  assign remaining = rem_q;
  assign expired   = (rem_q == CNT_W'(1));

endmodule

// File: rtl/airlock_sequencer.sv
// Two-door airlock phase sequencer on a 1 Hz clock. Define AIRLOCK_PURGE_EN to
// add a PURGE phase after every depressurize.
module airlock_sequencer
  import airlock_pkg::*;
#(
  parameter int CNT_W     = CNT_W_DEF,
  parameter int T_DOOR    = T_DOOR_DEF,
  parameter int T_PRESS   = T_PRESS_DEF,
  parameter int T_DEPRESS = T_DEPRESS_DEF,
  parameter int T_PURGE   = T_PURGE_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ent_req,
  input  logic             exit_req,
  input  logic             door_clear,
  output logic             outer_open,
  output logic             inner_open,
  output logic             pump_on,
  output logic             vent_on,
  output logic             purge_on,
  output logic             busy,
  output logic             ent_ack,
  output logic             exit_ack,
  output logic [CNT_W-1:0] secs_left,
  output logic [2:0]       state_dbg
);

  localparam logic [CNT_W-1:0] D_DOOR    = CNT_W'(T_DOOR);
  localparam logic [CNT_W-1:0] D_PRESS   = CNT_W'(T_PRESS);
  localparam logic [CNT_W-1:0] D_DEPRESS = CNT_W'(T_DEPRESS);
`ifdef AIRLOCK_PURGE_EN
  localparam logic [CNT_W-1:0] D_PURGE   = CNT_W'(T_PURGE);
`else
  logic unused_purge;
  assign unused_purge = ^T_PURGE;
`endif

  state_t           state_q, state_d;
  dir_e             dir_q, dir_d;
  logic             ent_ack_q, ent_ack_d;
  logic             exit_ack_q, exit_ack_d;
  logic             t_load, t_clear, t_expired, depress_done;
  logic [CNT_W-1:0] t_dur, t_rem;

  phase_timer #(.CNT_W(CNT_W)) u_timer (
    .clk       (clk),
    .rst       (reset),
    .load      (t_load),
    .clear     (t_clear),
    .dur       (t_dur),
    .remaining (t_rem),
    .expired   (t_expired)
  );

  // Requests are only looked at in the idle states; the pressure-matching
  // request wins, which makes the two requesters alternate when both wait.
  always_comb begin
    state_d      = state_q;
    dir_d        = dir_q;
    ent_ack_d    = 1'b0;
    exit_ack_d   = 1'b0;
    t_load       = 1'b0;
    t_clear      = 1'b0;
    t_dur        = '0;
    depress_done = 1'b0;
    case (state_q)
      ST_IDLE_LO: begin
        if (ent_req) begin
          state_d = ST_OPEN_OUT; dir_d = DIR_ENT; t_load = 1'b1; t_dur = D_DOOR;
        end else if (exit_req) begin
          state_d = ST_PRESS; dir_d = DIR_NONE; t_load = 1'b1; t_dur = D_PRESS;
        end
      end
      ST_IDLE_HI: begin
        if (exit_req) begin
          state_d = ST_OPEN_IN; dir_d = DIR_EXT; t_load = 1'b1; t_dur = D_DOOR;
        end else if (ent_req) begin
          state_d = ST_DEPRESS; dir_d = DIR_NONE; t_load = 1'b1; t_dur = D_DEPRESS;
        end
      end
      ST_OPEN_OUT: begin
        if (t_expired && door_clear) begin
          if (dir_q == DIR_ENT) begin
            state_d = ST_PRESS; t_load = 1'b1; t_dur = D_PRESS;
          end else begin
            state_d = ST_IDLE_LO; dir_d = DIR_NONE; t_clear = 1'b1; exit_ack_d = 1'b1;
          end
        end
      end
      ST_PRESS: begin
        if (t_expired) begin
          if (dir_q == DIR_ENT) begin
            state_d = ST_OPEN_IN; t_load = 1'b1; t_dur = D_DOOR;
          end else begin
            state_d = ST_IDLE_HI; dir_d = DIR_NONE; t_clear = 1'b1;
          end
        end
      end
      ST_OPEN_IN: begin
        if (t_expired && door_clear) begin
          if (dir_q == DIR_ENT) begin
            state_d = ST_IDLE_HI; dir_d = DIR_NONE; t_clear = 1'b1; ent_ack_d = 1'b1;
          end else begin
            state_d = ST_DEPRESS; t_load = 1'b1; t_dur = D_DEPRESS;
          end
        end
      end
      ST_DEPRESS: begin
        if (t_expired) begin
`ifdef AIRLOCK_PURGE_EN
          state_d = ST_PURGE; t_load = 1'b1; t_dur = D_PURGE;
`else
          depress_done = 1'b1;
`endif
        end
      end
`ifdef AIRLOCK_PURGE_EN
      ST_PURGE: begin
        if (t_expired) depress_done = 1'b1;
      end
`endif
      default: begin
        state_d = ST_IDLE_LO; dir_d = DIR_NONE; t_clear = 1'b1;
      end
    endcase
    if (depress_done) begin
      if (dir_q == DIR_EXT) begin
        state_d = ST_OPEN_OUT; t_load = 1'b1; t_dur = D_DOOR;
      end else begin
        state_d = ST_IDLE_LO; dir_d = DIR_NONE; t_clear = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE_LO;
      dir_q      <= DIR_NONE;
      ent_ack_q  <= 1'b0;
      exit_ack_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      ent_ack_q  <= ent_ack_d;
      exit_ack_q <= exit_ack_d;
    end
  end

  assign outer_open = (state_q == ST_OPEN_OUT);
  assign inner_open = (state_q == ST_OPEN_IN);
  assign pump_on    = (state_q == ST_PRESS);
  assign vent_on    = (state_q == ST_DEPRESS);
`ifdef AIRLOCK_PURGE_EN
  assign purge_on   = (state_q == ST_PURGE);
`else
  assign purge_on   = 1'b0;
`endif
  assign busy       = (state_q != ST_IDLE_LO) && (state_q != ST_IDLE_HI);
  assign ent_ack    = ent_ack_q;
  assign exit_ack   = exit_ack_q;
  assign secs_left  = t_rem;
  assign state_dbg  = state_q;

endmodule

// File: doc/airlock_sequencer.md
# airlock_sequencer

Controller that sequences a two-door airlock chamber through timed phases using one shared countdown timer, running on the 1 Hz system clock so one cycle equals one second. It arbitrates between an entry requester (outside) and an exit requester (inside), drives the door, pump and vent outputs, and reloads the timer with the duration of each phase. Default durations are 5, 7 and 8 minutes.

## Interface
- CNT_W, 10: timer width; durations up to 1023 s.
- T_DOOR, 10: door-open phase length, seconds.
- T_PRESS, 300: pressurize phase length (5 min).
- T_DEPRESS, 420: depressurize phase length (7 min).
- T_PURGE, 480: purge phase length (8 min); used only with purge compiled in.

- clk  input  1  1 Hz clock, rising edge.
- reset  input  1  asynchronous, active-high; returns the block to the IDLE_LO state.
- ent_req  input  1  level; held by requester until ent_ack.
- exit_req  input  1  level; held by requester until exit_ack.
- door_clear  input  1  doorway unobstructed; gates the end of door phases.
- outer_open  output  1  outer door open command.
- inner_open  output  1  inner door open command.
- pump_on  output  1  pressurize.
- vent_on  output  1  depressurize.
- purge_on  output  1  purge flow.
- busy  output  1  state is neither IDLE_LO nor IDLE_HI.
- ent_ack  output  1  one-cycle pulse when entry completes.
- exit_ack  output  1  one-cycle pulse when exit completes.
- secs_left  output  CNT_W  seconds remaining in current phase; 0 when idle.

## Operation
- States: IDLE_LO (chamber at outside pressure), IDLE_HI (chamber at inside pressure), OPEN_OUT, PRESS, OPEN_IN, DEPRESS, PURGE. The direction register takes ENT, EXT or NONE, where NONE means an empty chamber transfer.
- IDLE_LO: if ent_req, go to OPEN_OUT with dir=ENT. Otherwise, if exit_req, go to PRESS with dir=NONE.
- IDLE_HI: if exit_req, go to OPEN_IN with dir=EXT. Otherwise, if ent_req, go to DEPRESS with dir=NONE.
- OPEN_OUT: ENT goes to PRESS. EXT goes to IDLE_LO and pulses exit_ack.
- PRESS: ENT goes to OPEN_IN. NONE goes to IDLE_HI.
- OPEN_IN: ENT goes to IDLE_HI and pulses ent_ack. EXT goes to DEPRESS.
- DEPRESS: EXT goes to OPEN_OUT. NONE goes to IDLE_LO. With purge compiled in, DEPRESS goes to PURGE first, and PURGE then takes these exits.
- Fairness: when both requests are pending, the request matching the current chamber pressure is served first. After that sequence completes, the chamber sits at the other pressure, so the other request is served next. Neither requester can starve.
- Requests are sampled only in idle states. Changes to a request during a sequence are ignored.
- Each output is a decode of the current state: outer_open in OPEN_OUT, inner_open in OPEN_IN, pump_on in PRESS, vent_on in DEPRESS, purge_on in PURGE.
- At most one door is open in any cycle.
- Door hold: a door phase ends only when its timer has expired and door_clear=1. While held, the door stays open and secs_left stays at 1.
- Durations of 0 are treated as 1. Values are truncated to CNT_W bits.

## Timing
- Reset (async): state=IDLE_LO, dir=NONE, timer cleared. All outputs are 0, including secs_left.
- Reset asserted mid-phase closes doors and stops pump, vent and purge immediately, without waiting for a clock edge.
- A phase of duration D occupies exactly D cycles when not held.
- secs_left equals D on the first cycle of a phase and counts down to 1 on its last cycle.
- State change to the next phase and reload of the timer both happen on the same edge. There are no gap cycles between phases.
- Idle-to-first-phase latency: 1 cycle after a request is sampled high.
- Acks are asserted in the first idle cycle after the sequence completes.

## Configuration
- AIRLOCK_PURGE_EN defined: the PURGE state exists and follows every DEPRESS for T_PURGE cycles with purge_on=1.
- AIRLOCK_PURGE_EN undefined: the PURGE state and its timer load are absent, purge_on is tied to 0, and DEPRESS exits directly.

## Structure
- Package airlock_pkg:
  - state enum;
  - direction enum (ENT/EXT/NONE);
  - default duration constants: 10, 300, 420, 480.
- Sub-module phase_timer:
  - load/dur inputs;
  - remaining and expired (remaining==1) outputs;
  - countdown holds at 1 when the controller holds the phase.
- The controller instantiates exactly one phase_timer.

## Test plan
- Entry from reset: ent_req=1 sampled at cycle 0.
  - outer_open in cycles 1–10, pump_on in 11–310, inner_open in 311–320.
  - ent_ack in cycle 321, with state IDLE_HI.
- Exit from IDLE_HI, purge undefined: inner_open 10 cycles, vent_on 420, outer_open 10.
  - exit_ack in cycle 441.
  - secs_left reads 420 in the first vent cycle.
- Simultaneous ent_req and exit_req in IDLE_LO: the entry sequence runs first.
  - The exit sequence starts in the cycle after ent_ack.
  - No extra PRESS or DEPRESS phase between the two sequences.
- door_clear=0 held for 25 cycles at the end of OPEN_OUT: outer_open lasts 35 cycles and secs_left holds at 1.
  - The PRESS phase length is unchanged at 300.
- Reset asserted mid-PRESS between clock edges: all outputs fall to 0 without waiting for a clock edge.
  - After release, the block is in IDLE_LO and secs_left=0.
- AIRLOCK_PURGE_EN defined, exit sequence: purge_on for 480 cycles between vent_on and outer_open.
  - exit_ack in cycle 921.
